vend_ctrl: RTL
==============

# vend_ctrl

Parametrised vending-machine controller, successor to the fixed four-item FSM. Accumulates inserted coins into a registered credit, checks a selected item's price and stock from a run-time-loadable table, dispenses, and returns exact change. Sits between the coin/keypad front end and the dispenser/change-hopper drivers.

## Interface
- N_ITEMS, 4, number of products (2..16)
- MONEY_W, 8, width of price, credit and change
- STOCK_W, 4, width of per-item stock counter
- DENOM0..DENOM3, 5/10/20/50, coin values selected by coin_sel 0..3
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE
- cancel  in  1  abort current purchase
- continue_buy  in  1  sampled in CHANGE: buy again without re-start
- done_money  in  1  customer finished inserting coins
- cfg_we  in  1  table write strobe (IDLE only)
- cfg_item  in  $clog2(N_ITEMS)  table index
- cfg_price  in  MONEY_W  price to store
- cfg_stock  in  STOCK_W  stock count to store
- sel_valid  in  1  item selection strobe
- item_in  in  $clog2(N_ITEMS)  selected item
- coin_valid  in  1  one coin inserted this cycle
- coin_sel  in  2  denomination index
- state  out  3  IDLE=0 SELECT=1 RECEIVE=2 COMPARE=3 DISPENSE=4 CHANGE=5
- credit  out  MONEY_W  accumulated credit
- price  out  MONEY_W  latched price of selected item
- coin_reject  out  1  one-cycle pulse: coin refused
- sold_out  out  1  one-cycle pulse: selected item stock is 0
- dispense  out  1  one-cycle pulse: release item
- dispense_item  out  $clog2(N_ITEMS)  item being released
- change_valid  out  1  one-cycle pulse: change_amt is valid
- change_amt  out  MONEY_W  change/refund amount

## Operation
- Reset: state=IDLE; credit, price, dispense_item, change_amt=0; all pulses 0; price table=0, stock table=0.
- IDLE: cfg_we writes price/stock[cfg_item]; writes ignored in any other state. start -> SELECT.
- SELECT: cancel -> IDLE (priority). sel_valid with stock[item_in]==0 -> sold_out pulse, stay. sel_valid with stock>0 -> latch price and dispense_item, -> RECEIVE. No sel_valid -> stay.
- RECEIVE, priority cancel > coin > done: cancel -> CHANGE (full refund). coin_valid: if credit+DENOM[coin_sel] > 2^MONEY_W-1, credit unchanged and coin_reject pulse; else credit += DENOM. done_money, or credit (post-update) >= price -> COMPARE. Coin and done_money in same cycle: coin counted, then COMPARE.
- COMPARE: credit >= price -> DISPENSE; else -> RECEIVE (credit kept).
- DISPENSE: dispense pulse; stock[dispense_item] -= 1; credit -= price -> CHANGE.
- CHANGE: change_valid pulse with change_amt = credit (0 allowed); credit cleared. continue_buy -> SELECT, else IDLE. change_amt holds until next change_valid.
- Arithmetic: sum computed MONEY_W+1 wide for overflow test; credit never wraps; stock never underflows (DISPENSE only reachable with stock>0).
- cancel outside SELECT/RECEIVE ignored.

## Timing
- All outputs registered; pulses asserted the cycle after the causing input is sampled, for exactly one cycle.
- Best-case purchase: start, sel, coin(s) reaching price -> COMPARE -> DISPENSE -> CHANGE: 1 cycle per state after RECEIVE.
- credit reflects an accepted coin the cycle after coin_valid.
- reset_n low at any time: immediate return to reset values, tables cleared, in-flight credit lost (no change pulse).

## Test plan
- Load item1 price 15 stock 2; start, select 1, coins 10+10 -> COMPARE, dispense pulse item 1, change_amt=5, stock1=1.
- Select item with stock 0 -> sold_out pulse, state stays SELECT; cancel -> IDLE, no change_valid.
- Price 40, coin 20, cancel -> CHANGE, change_amt=20, credit 0, no dispense.
- MONEY_W=8, credit 240, insert 50 -> coin_reject, credit stays 240; insert 10 -> credit 250.
- Price 30, coin 10, done_money -> COMPARE -> RECEIVE, credit 10 retained; coin 20 -> dispense, change 0, continue_buy -> SELECT.
- Assert reset_n mid-RECEIVE with credit 25 -> state IDLE, credit 0, tables zero, no pulses.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accumulation, run-time price/stock table, dispense and exact change.
// Every output is registered. Pulses appear the cycle after their cause. No backpressure; strobes are sampled once per cycle.
module vend_ctrl #(
  parameter int N_ITEMS = 4,
  parameter int MONEY_W = 8,
  parameter int STOCK_W = 4,
  parameter int DENOM0  = 5,
  parameter int DENOM1  = 10,
  parameter int DENOM2  = 20,
  parameter int DENOM3  = 50,
  localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               cancel,
  input  logic               continue_buy,
  input  logic               done_money,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_item,
  input  logic [MONEY_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   item_in,
  input  logic               coin_valid,
  input  logic [1:0]         coin_sel,
  output logic [2:0]         state,
  output logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] price,
  output logic               coin_reject,
  output logic               sold_out,
  output logic               dispense,
  output logic [IDX_W-1:0]   dispense_item,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_RECEIVE  = 3'd2;
  localparam logic [2:0] S_COMPARE  = 3'd3;
  localparam logic [2:0] S_DISPENSE = 3'd4;
  localparam logic [2:0] S_CHANGE   = 3'd5;

  logic [2:0]         r_state;
  logic [MONEY_W-1:0] r_credit;
  logic [MONEY_W-1:0] r_price;
  logic [IDX_W-1:0]   r_item;
  logic [MONEY_W-1:0] r_change_amt;
  logic               r_coin_reject;
  logic               r_sold_out;
  logic               r_dispense;
  logic               r_change_valid;
  logic [MONEY_W-1:0] r_price_tab [N_ITEMS];
  logic [STOCK_W-1:0] r_stock_tab [N_ITEMS];

  logic [MONEY_W-1:0] w_denom;
  logic [MONEY_W:0]   w_sum;
  logic               w_coin_ok;
  logic [MONEY_W-1:0] w_credit_rcv;

  always_comb begin
    w_denom = '0;
    case (coin_sel)
      2'd0:    w_denom = MONEY_W'(DENOM0);
      2'd1:    w_denom = MONEY_W'(DENOM1);
      2'd2:    w_denom = MONEY_W'(DENOM2);
      default: w_denom = MONEY_W'(DENOM3);
    endcase
  end

  // One extra bit on the sum exposes overflow, so credit saturates by refusal instead of wrapping.
  assign w_sum        = {1'b0, r_credit} + {1'b0, w_denom};
  assign w_coin_ok    = coin_valid && !w_sum[MONEY_W];
  assign w_credit_rcv = w_coin_ok ? w_sum[MONEY_W-1:0] : r_credit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_price        <= '0;
      r_item         <= '0;
      r_change_amt   <= '0;
      r_coin_reject  <= 1'b0;
      r_sold_out     <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        r_price_tab[i] <= '0;
        r_stock_tab[i] <= '0;
      end
    end else begin
      r_coin_reject  <= 1'b0;
      r_sold_out     <= 1'b0;
      r_dispense     <= 1'b0;
      r_change_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) begin
            r_price_tab[cfg_item] <= cfg_price;
            r_stock_tab[cfg_item] <= cfg_stock;
          end
          if (start) r_state <= S_SELECT;
        end
        S_SELECT: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else if (sel_valid) begin
            if (r_stock_tab[item_in] == '0) begin
              r_sold_out <= 1'b1;
            end else begin
              r_price <= r_price_tab[item_in];
              r_item  <= item_in;
              r_state <= S_RECEIVE;
            end
          end
        end
        S_RECEIVE: begin
          if (cancel) begin
            r_state <= S_CHANGE;
          end else begin
            if (coin_valid && !w_coin_ok) r_coin_reject <= 1'b1;
            r_credit <= w_credit_rcv;
            if (done_money || (w_credit_rcv >= r_price)) r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_state <= (r_credit >= r_price) ? S_DISPENSE : S_RECEIVE;
        end
        S_DISPENSE: begin
          r_dispense          <= 1'b1;
          r_stock_tab[r_item] <= r_stock_tab[r_item] - STOCK_W'(1);
          r_credit            <= r_credit - r_price;
          r_state             <= S_CHANGE;
        end
        S_CHANGE: begin
          r_change_valid <= 1'b1;
          r_change_amt   <= r_credit;
          r_credit       <= '0;
          r_state        <= continue_buy ? S_SELECT : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state         = r_state;
  assign credit        = r_credit;
  assign price         = r_price;
  assign coin_reject   = r_coin_reject;
  assign sold_out      = r_sold_out;
  assign dispense      = r_dispense;
  assign dispense_item = r_item;
  assign change_valid  = r_change_valid;
  assign change_amt    = r_change_amt;

endmodule
